// File: rtl/sa_pkg.sv
// Shared types and constants for the 2x2 systolic-array feeder.
package sa_pkg;

  localparam int SA_DW     = 8;
  localparam int SA_LEN_W  = 8;
  localparam int SKEW_ROWS = 1;
  localparam int DRAIN_CYC = 4;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC);
  // Tag line reaches the bottom row of column 2, one PE beyond column 1.
  localparam int TAG_LEN   = SKEW_ROWS + 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOADW0 = 3'd2,
    ST_LOADW1 = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } sa_state_e;

  function automatic logic is_compute(input sa_state_e s);
    return (s == ST_STREAM) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sa_skew_pipe.sv
// Row-skew registers for the activation inputs plus the column result-tag delay line.
module sa_skew_pipe
  import sa_pkg::*;
#(
  parameter int DW = SA_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_xfer,
  input  logic [DW-1:0] i_x1,
  input  logic [DW-1:0] i_x2,
  output logic [DW-1:0] o_act1,
  output logic [DW-1:0] o_act2,
  output logic [1:0]    o_col_valid
);

  logic [DW-1:0]      r_act1;
  logic [DW-1:0]      r_x2d;
  logic [DW-1:0]      r_act2;
  logic [TAG_LEN-1:0] r_tag;

  // Non-transfer cycles inject a zero bubble and an empty tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act1 <= {DW{1'b0}};
      r_x2d  <= {DW{1'b0}};
      r_act2 <= {DW{1'b0}};
      r_tag  <= {TAG_LEN{1'b0}};
    end else begin
      r_act1 <= i_xfer ? i_x1 : {DW{1'b0}};
      r_x2d  <= i_xfer ? i_x2 : {DW{1'b0}};
      r_act2 <= r_x2d;
      r_tag  <= {r_tag[TAG_LEN-2:0], i_xfer};
    end
  end

  assign o_act1      = r_act1;
  assign o_act2      = r_act2;
  assign o_col_valid = {r_tag[SKEW_ROWS+2], r_tag[SKEW_ROWS+1]};

endmodule

// File: rtl/sa2x2_feeder.sv
// Job sequencer feeding a 2x2 weight-stationary systolic array.
// Optional column bias inputs are compiled in with SA_FEEDER_BIAS_EN.
module sa2x2_feeder
  import sa_pkg::*;
#(
  parameter int DW    = SA_DW,
  parameter int LEN_W = SA_LEN_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [DW-1:0]   i_w11,
  input  logic [DW-1:0]   i_w12,
  input  logic [DW-1:0]   i_w21,
  input  logic [DW-1:0]   i_w22,
  input  logic [LEN_W-1:0] i_num_vec,
  input  logic            i_act_valid,
  input  logic [2*DW-1:0] i_act_data,
`ifdef SA_FEEDER_BIAS_EN
  input  logic [DW-1:0]   i_bias1,
  input  logic [DW-1:0]   i_bias2,
`endif
  output logic            o_act_ready,
  output logic            o_clear,
  output logic            o_weight_load,
  output logic [DW-1:0]   o_w_in1,
  output logic [DW-1:0]   o_w_in2,
  output logic [DW-1:0]   o_act_in1,
  output logic [DW-1:0]   o_act_in2,
  output logic [DW-1:0]   o_psum_in1,
  output logic [DW-1:0]   o_psum_in2,
  output logic [1:0]      o_col_valid,
  output logic            o_busy,
  output logic            o_done
);

  sa_state_e         r_state, w_next;
  logic [DW-1:0]     r_w11, r_w12, r_w21, r_w22;
  logic [LEN_W-1:0]  r_num, r_cnt, w_cnt_inc;
  logic [DRAIN_W-1:0] r_drain;
  logic              r_clear, r_wload, r_busy, r_done;
  logic [DW-1:0]     r_w_in1, r_w_in2;
  logic              w_clear, w_wload;
  logic [DW-1:0]     w_w_in1, w_w_in2;
  logic              w_act_ready, w_xfer, w_accept;

  assign w_act_ready = (r_state == ST_STREAM);
  assign w_xfer      = i_act_valid && w_act_ready;
  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_cnt_inc   = r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};

  // Next-state decode and the Moore output values for the coming cycle.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_wload = 1'b0;
    w_w_in1 = {DW{1'b0}};
    w_w_in2 = {DW{1'b0}};
    case (r_state)
      ST_IDLE:   if (i_start) w_next = ST_CLEAR; else w_next = ST_IDLE;
      ST_CLEAR:  w_next = ST_LOADW0;
      ST_LOADW0: w_next = ST_LOADW1;
      ST_LOADW1: if (r_num != {LEN_W{1'b0}}) w_next = ST_STREAM; else w_next = ST_DONE;
      ST_STREAM: if (w_xfer && (w_cnt_inc == r_num)) w_next = ST_DRAIN; else w_next = ST_STREAM;
      ST_DRAIN:  if (r_drain == DRAIN_W'(DRAIN_CYC - 1)) w_next = ST_DONE; else w_next = ST_DRAIN;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    case (w_next)
      ST_CLEAR:  w_clear = 1'b1;
      ST_LOADW0: begin w_wload = 1'b1; w_w_in1 = r_w21; w_w_in2 = r_w22; end
      ST_LOADW1: begin w_wload = 1'b1; w_w_in1 = r_w11; w_w_in2 = r_w12; end
      default:   w_wload = 1'b0;
    endcase
  end

  // State, job latches, counters and registered control outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_w11   <= {DW{1'b0}};
      r_w12   <= {DW{1'b0}};
      r_w21   <= {DW{1'b0}};
      r_w22   <= {DW{1'b0}};
      r_num   <= {LEN_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_drain <= {DRAIN_W{1'b0}};
      r_clear <= 1'b0;
      r_wload <= 1'b0;
      r_w_in1 <= {DW{1'b0}};
      r_w_in2 <= {DW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_w11 <= i_w11;
        r_w12 <= i_w12;
        r_w21 <= i_w21;
        r_w22 <= i_w22;
        r_num <= i_num_vec;
        r_cnt <= {LEN_W{1'b0}};
      end else if (w_xfer) begin
        r_cnt <= w_cnt_inc;
      end
      r_drain <= (r_state == ST_DRAIN) ? r_drain + {{(DRAIN_W-1){1'b0}}, 1'b1} : {DRAIN_W{1'b0}};
      r_clear <= w_clear;
      r_wload <= w_wload;
      r_w_in1 <= w_w_in1;
      r_w_in2 <= w_w_in2;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
    end
  end

`ifdef SA_FEEDER_BIAS_EN
  logic [DW-1:0] r_bias1, r_bias2, r_psum1, r_psum2;

  // Bias is latched with the job and presented only while results are forming.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bias1 <= {DW{1'b0}};
      r_bias2 <= {DW{1'b0}};
      r_psum1 <= {DW{1'b0}};
      r_psum2 <= {DW{1'b0}};
    end else begin
      if (w_accept) begin
        r_bias1 <= i_bias1;
        r_bias2 <= i_bias2;
      end
      r_psum1 <= is_compute(w_next) ? r_bias1 : {DW{1'b0}};
      r_psum2 <= is_compute(w_next) ? r_bias2 : {DW{1'b0}};
    end
  end

  assign o_psum_in1 = r_psum1;
  assign o_psum_in2 = r_psum2;
`else
  assign o_psum_in1 = {DW{1'b0}};
  assign o_psum_in2 = {DW{1'b0}};
`endif

  sa_skew_pipe #(.DW(DW)) u_skew (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_xfer      (w_xfer),
    .i_x1        (i_act_data[DW-1:0]),
    .i_x2        (i_act_data[2*DW-1:DW]),
    .o_act1      (o_act_in1),
    .o_act2      (o_act_in2),
    .o_col_valid (o_col_valid)
  );

  assign o_act_ready   = w_act_ready;
  assign o_clear       = r_clear;
  assign o_weight_load = r_wload;
  assign o_w_in1       = r_w_in1;
  assign o_w_in2       = r_w_in2;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
